imem_loader: RTL and testbench

- Write-side counterpart of the instruction memory. The processor core only reads that memory, through the PC.
- Accepts a byte stream on a valid/ready interface and packs bytes into 32-bit big-endian instruction words.
- Writes each word into instruction memory through a dedicated write port.
- Holds the program counter in reset until a load completes, then releases it.
- Sits between the host or debug link and the instruction memory; its cpu_hold output drives the PC reset.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_byte_packer.sv | 27 ++
 rtl/imem_loader.sv | 124 ++++++++++++
 tb/tb_imem_loader.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and sizing.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  function automatic int max_words(input int addr_w);
    return (1 << addr_w) / BYTES_PER_WORD;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte packer: shifts bytes in MSB-first and counts bytes of the current word.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] byte_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (shift_en) begin
      word     <= {word[23:0], byte_in};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // Three bytes held: the next shift completes the word.
  assign word_full = (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory as 32-bit words and holds the core in reset
// until a load completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = max_words(ADDR_W),
  parameter int LEN_W     = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // state | meaning
  // IDLE  | waiting for start; cpu_hold reflects last load outcome
  // RECV  | accepting stream bytes into the packer
  // WRITE | one-cycle write of the packed word
  // DONE  | one-cycle completion pulse, then back to IDLE

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, word_cnt_q;
  logic              done_zero_q, err_q;
  logic              pk_clear, pk_shift, pk_full;
  logic [31:0]       pk_word;
  logic              len_ok, len_zero, len_big, last_word;

  assign len_zero  = (len_words == '0);
  assign len_big   = (len_words > LEN_W'(MAX_WORDS));
  assign len_ok    = !len_zero && !len_big;
  assign last_word = (word_cnt_q == len_q - 1'b1);

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .shift_en  (pk_shift),
    .byte_in   (byte_data),
    .word      (pk_word),
    .word_full (pk_full)
  );

  always_comb begin
    state_d  = state_q;
    pk_clear = 1'b0;
    pk_shift = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && len_ok) begin
          state_d  = RECV;
          pk_clear = 1'b1;
        end
      end
      RECV: begin
        if (byte_valid) begin
          pk_shift = 1'b1;
          if (pk_full) state_d = WRITE;
        end
      end
      WRITE:   state_d = last_word ? DONE : RECV;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      im_addr     <= '0;
      cpu_hold    <= 1'b1;
      done_zero_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_zero_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len_zero) begin
              done_zero_q <= 1'b1;
              cpu_hold    <= 1'b0;
            end else if (len_big) begin
              err_q <= 1'b1;
            end else begin
              len_q      <= len_words;
              word_cnt_q <= '0;
              im_addr    <= '0;
              cpu_hold   <= 1'b1;
            end
          end
        end
        WRITE: begin
          word_cnt_q <= word_cnt_q + 1'b1;
          im_addr    <= im_addr + ADDR_W'(BYTES_PER_WORD);
          // Release the core in the same cycle done is shown.
          if (last_word) cpu_hold <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign byte_ready = (state_q == RECV);
  assign im_we      = (state_q == WRITE);
  assign im_wdata   = pk_word;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE) || done_zero_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: behavioural model compared every cycle,
// plus literal expectations for the directed loads.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset, start, byte_valid;
  logic [6:0] len_words;
  logic [7:0] byte_data;
  logic       byte_ready, im_we, cpu_hold, busy, done, err;
  logic [7:0] im_addr;
  logic [31:0] im_wdata;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .len_words(len_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: load progress expressed as byte/word counts.
  bit        m_active, m_wr, m_fin, m_hold, m_done, m_err;
  int        m_len, m_nwords, m_nbytes;
  logic [31:0] m_word;
  logic [39:0] wlog[$];
  int        cyc = 0, t0 = 0, load_cycles = 0;
  bit        s_reset, s_start, s_valid, was_active;
  int        s_len;
  logic [7:0] s_data;

  always @(posedge clk) begin
    s_reset = reset; s_start = start; s_valid = byte_valid;
    s_len = int'(len_words); s_data = byte_data;
    was_active = m_active;
    cyc++;
    if (s_reset) begin
      m_active = 0; m_wr = 0; m_fin = 0; m_hold = 1; m_done = 0; m_err = 0;
      m_len = 0; m_nwords = 0; m_nbytes = 0; m_word = '0;
    end else begin
      bit dn, er;
      dn = 0; er = 0;
      if (!m_active) begin
        if (s_start) begin
          if (s_len == 0) begin dn = 1; m_hold = 0; end
          else if (s_len > 64) er = 1;
          else begin
            m_active = 1; m_len = s_len; m_nwords = 0; m_nbytes = 0;
            m_word = '0; m_hold = 1; t0 = cyc;
          end
        end
      end else if (m_fin) begin
        m_active = 0; m_fin = 0;
      end else if (m_wr) begin
        m_wr = 0; m_nwords++;
        if (m_nwords == m_len) begin m_fin = 1; dn = 1; m_hold = 0; end
      end else if (s_valid) begin
        m_word = {m_word[23:0], s_data};
        m_nbytes++;
        if (m_nbytes == 4) begin m_nbytes = 0; m_wr = 1; end
      end
      m_done = dn; m_err = er;
    end
    #1;
    check("byte_ready", 32'(byte_ready), 32'(m_active && !m_wr && !m_fin));
    check("im_we", 32'(im_we), 32'(m_wr));
    check("im_addr", 32'(im_addr), 32'((4 * m_nwords) & 8'hFF));
    check("cpu_hold", 32'(cpu_hold), 32'(m_hold));
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_done));
    check("err", 32'(err), 32'(m_err));
    if (m_wr) check("im_wdata", im_wdata, m_word);
    if (im_we) wlog.push_back({im_addr, im_wdata});
    if (done && busy) load_cycles = cyc - t0 + 2;  // start cycle through done cycle
  end

  logic [7:0] tb_bytes [0:255];

  task automatic do_start(input int len);
    @(negedge clk);
    start = 1'b1; len_words = 7'(len);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at a negedge. mode 0: no gaps, 1: alternate, 2: random.
  task automatic stream(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      int gaps, guard;
      gaps = (mode == 1) ? ((i > 0) ? 1 : 0) : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gaps) begin byte_valid = 1'b0; @(negedge clk); end
      byte_valid = 1'b1; byte_data = tb_bytes[i];
      guard = 0;
      while (!byte_ready && guard < 40) begin @(negedge clk); guard++; end
      if (guard >= 40) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) check("idle_timeout", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    logic [7:0] t1 [0:7];
    int wl;
    t1 = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
    reset = 1'b1; start = 1'b0; len_words = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (2) @(negedge clk);
    check("reset_hold", 32'(cpu_hold), 32'd1);
    check("reset_addr", 32'(im_addr), 32'd0);
    reset = 1'b0;

    // Two-word load, continuous stream.
    for (int i = 0; i < 8; i++) tb_bytes[i] = t1[i];
    wlog.delete();
    do_start(2); stream(8, 0); wait_idle();
    check("t1_nwrites", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      check("t1_w0", wlog[0][31:0], 32'h20080005);
      check("t1_a0", 32'(wlog[0][39:32]), 32'h0);
      check("t1_w1", wlog[1][31:0], 32'h00000008);
      check("t1_a1", 32'(wlog[1][39:32]), 32'h4);
    end
    check("t1_cycles", 32'(load_cycles), 32'd12);
    check("t1_hold", 32'(cpu_hold), 32'd0);

    // Same load with alternating byte_valid.
    pulse_reset(); wlog.delete();
    do_start(2); stream(8, 1); wait_idle();
    check("t2_nwrites", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      check("t2_w0", wlog[0][31:0], 32'h20080005);
      check("t2_w1", wlog[1][31:0], 32'h00000008);
    end

    // Rejected / empty lengths.
    pulse_reset(); wlog.delete();
    do_start(65); wait_idle();
    check("t3_hold", 32'(cpu_hold), 32'd1);
    do_start(0); wait_idle();
    check("t3_hold0", 32'(cpu_hold), 32'd0);
    check("t3_nwrites", 32'(wlog.size()), 32'd0);

    // Full capacity with an incrementing pattern.
    for (int i = 0; i < 256; i++) tb_bytes[i] = 8'(i);
    wlog.delete();
    do_start(64); stream(256, 0); wait_idle();
    wl = wlog.size();
    check("t4_nwrites", 32'(wl), 32'd64);
    if (wl == 64) begin
      check("t4_last_addr", 32'(wlog[63][39:32]), 32'hFC);
      check("t4_last_data", wlog[63][31:0], 32'hFCFDFEFF);
    end
    check("t4_cycles", 32'(load_cycles), 32'd322);

    // Reset after 2 bytes of word 1 of a 3-word load, then a clean load.
    wlog.delete();
    do_start(3); stream(6, 0);
    pulse_reset(); @(negedge clk);
    check("t5_nwrites", 32'(wlog.size()), 32'd1);
    check("t5_hold", 32'(cpu_hold), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    do_start(3); stream(12, 2); wait_idle();
    check("t5_nwrites2", 32'(wlog.size()), 32'd4);
    check("t5_hold2", 32'(cpu_hold), 32'd0);

    // Start pulsed mid-load is ignored.
    wlog.delete();
    do_start(2); stream(3, 0);
    do_start(5); stream(5, 0); wait_idle();
    check("t6_nwrites", 32'(wlog.size()), 32'd2);

    // Randomized loads and starts.
    for (int r = 0; r < 20; r++) begin
      int len;
      for (int i = 0; i < 256; i++) tb_bytes[i] = 8'($urandom);
      case ($urandom_range(0, 5))
        0: len = 0;
        1: len = int'($urandom_range(65, 127));
        default: len = int'($urandom_range(1, 8));
      endcase
      if ($urandom_range(0, 4) == 0) pulse_reset();
      do_start(len);
      if (len >= 1 && len <= 64) stream(4 * len, 2);
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
